// File: rtl/wb_pipe_stage_pkg.sv
// Shared constants and types for the writeback pipeline stage.
package wb_pipe_stage_pkg;

   // Head entry plus one skid entry.
   localparam int FIFO_DEPTH = 2;
   // Occupancy counter width, enough to hold 0..FIFO_DEPTH.
   localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

   typedef logic [OCC_W-1:0] occ_t;

   // Entry layout is {flag, addr, data}, flag in the MSB. The struct itself
   // is declared in the top because its field widths follow module parameters.
   localparam int ENTRY_FLAG_BITS = 1;

endpackage

// File: rtl/wb_pipe_stage_src_mux.sv
// One-hot result-source mux; the lowest set select bit wins, no bit set gives 0.
module wb_src_mux #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 32
) (
   input  logic [NUM_SRC-1:0]        i_sel,
   input  logic [NUM_SRC*DATA_W-1:0] i_data,
   output logic [DATA_W-1:0]         o_data
);

   // Scan from the top so the lowest set index is the last assignment to stick.
   always_comb begin
      o_data = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (i_sel[k]) o_data = i_data[k*DATA_W +: DATA_W];
      end
   end

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback stage: source select, 2-entry skid FIFO toward the regfile,
// flush, x0-write suppression and a retired-write counter.
module wb_pipe_stage
   import wb_pipe_stage_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int ADDR_W        = 5,
   parameter int NUM_SRC       = 4,
   parameter bit ZERO_SUPPRESS = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic                      in_flag_i,
   input  logic [ADDR_W-1:0]         in_addr_i,
   input  logic [NUM_SRC-1:0]        in_sel_i,
   input  logic [NUM_SRC*DATA_W-1:0] in_data_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic                      wb_flag_o,
   output logic [ADDR_W-1:0]         wb_addr_o,
   output logic [DATA_W-1:0]         wb_data_o,
   output logic [CNT_W-1:0]          wb_cnt_o
);

   typedef struct packed {
      logic              flag;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            r_head;
   entry_t            r_skid;
   occ_t              r_occ;
   logic [CNT_W-1:0]  r_wb_cnt;

   logic [DATA_W-1:0] w_sel_data;
   logic              w_zero_wr;
   entry_t            w_new;
   logic              w_push;
   logic              w_pop;

   wb_src_mux #(
      .NUM_SRC (NUM_SRC),
      .DATA_W  (DATA_W)
   ) u_src_mux (
      .i_sel  (in_sel_i),
      .i_data (in_data_i),
      .o_data (w_sel_data)
   );

   // Build the incoming entry; writes to x0 lose their flag when suppression is on.
   always_comb begin
      w_zero_wr  = ZERO_SUPPRESS && (in_addr_i == '0);
      w_new.flag = in_flag_i & ~w_zero_wr;
      w_new.addr = in_addr_i;
      w_new.data = w_sel_data;
   end

   // Ready depends only on occupancy, so no combinational path from out_ready_i.
   assign in_ready_o  = (r_occ < occ_t'(FIFO_DEPTH));
   assign out_valid_o = (r_occ != '0);
   assign w_push      = in_valid_i & in_ready_o & ~flush_i;
   assign w_pop       = out_valid_o & out_ready_i;

   // Head/skid storage; vacated entries keep addr/data but always drop their flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head <= '0;
         r_skid <= '0;
         r_occ  <= '0;
      end else if (flush_i) begin
         r_head.flag <= 1'b0;
         r_skid.flag <= 1'b0;
         r_occ       <= '0;
      end else begin
         case (r_occ)
            occ_t'(0): begin
               if (w_push) begin
                  r_head <= w_new;
                  r_occ  <= occ_t'(1);
               end
            end
            occ_t'(1): begin
               if (w_push && w_pop) begin
                  r_head <= w_new;
               end else if (w_push) begin
                  r_skid <= w_new;
                  r_occ  <= occ_t'(2);
               end else if (w_pop) begin
                  r_head.flag <= 1'b0;
                  r_occ       <= occ_t'(0);
               end
            end
            default: begin
               // Full: push is impossible, a pop promotes the skid entry.
               if (w_pop) begin
                  r_head      <= r_skid;
                  r_skid.flag <= 1'b0;
                  r_occ       <= occ_t'(1);
               end
            end
         endcase
      end
   end

   // Count retired register writes; a flush cycle's pop does not retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb_cnt <= '0;
      end else if (!flush_i && w_pop && r_head.flag) begin
         r_wb_cnt <= r_wb_cnt + 1'b1;
      end
   end

   assign wb_flag_o = r_head.flag;
   assign wb_addr_o = r_head.addr;
   assign wb_data_o = r_head.data;
   assign wb_cnt_o  = r_wb_cnt;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed bench for wb_pipe_stage with hand-computed expectations.
module tb_wb_pipe_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush_i;
   logic         in_valid_i;
   logic         in_ready_o;
   logic         in_flag_i;
   logic [4:0]   in_addr_i;
   logic [3:0]   in_sel_i;
   logic [127:0] in_data_i;
   logic         out_valid_o;
   logic         out_ready_i;
   logic         wb_flag_o;
   logic [4:0]   wb_addr_o;
   logic [31:0]  wb_data_o;
   logic [31:0]  wb_cnt_o;

   int total = 0;
   int bad   = 0;

   wb_pipe_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_flag_i   (in_flag_i),
      .in_addr_i   (in_addr_i),
      .in_sel_i    (in_sel_i),
      .in_data_i   (in_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .wb_flag_o   (wb_flag_o),
      .wb_addr_o   (wb_addr_o),
      .wb_data_o   (wb_data_o),
      .wb_cnt_o    (wb_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic f, input logic [4:0] a,
                        input logic [3:0] s, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
      in_valid_i = v;
      in_flag_i  = f;
      in_addr_i  = a;
      in_sel_i   = s;
      in_data_i  = {d3, d2, d1, d0};
   endtask

   task automatic test_reset();
      rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 4'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      #12;
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
      total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
      total++; if ({wb_flag_o, wb_addr_o, wb_data_o, wb_cnt_o} !== 70'd0) begin bad++;
         $display("FAIL reset_outs got=%b/%h/%h/%h exp=0", wb_flag_o, wb_addr_o, wb_data_o, wb_cnt_o); end
      @(negedge clk); rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      out_ready_i = 1'b1;
      drive(1'b1, 1'b1, 5'd5, 4'b0010, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
      step();
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid_o); end
      total++; if (wb_addr_o !== 5'd5) begin bad++; $display("FAIL basic_addr got=%0d exp=5", wb_addr_o); end
      total++; if (wb_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_data got=%h exp=deadbeef", wb_data_o); end
      total++; if (wb_flag_o !== 1'b1) begin bad++; $display("FAIL basic_flag got=%b exp=1", wb_flag_o); end
      in_valid_i = 1'b0;
      step();
      total++; if (wb_cnt_o !== 32'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", wb_cnt_o); end
      total++; if (out_valid_o !== 1'b0 || wb_flag_o !== 1'b0) begin bad++;
         $display("FAIL basic_drain got=%b/%b exp=0/0", out_valid_o, wb_flag_o); end
      total++; if (wb_data_o !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_hold got=%h exp=deadbeef", wb_data_o); end
   endtask

   task automatic test_backpressure();
      out_ready_i = 1'b0;
      drive(1'b1, 1'b1, 5'd1, 4'b0001, 32'hA, 32'h0, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b1, 5'd2, 4'b0001, 32'hB, 32'h0, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b1, 5'd3, 4'b0001, 32'hC, 32'h0, 32'h0, 32'h0);
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b exp=0", in_ready_o); end
      step();
      total++; if (wb_data_o !== 32'hA || in_ready_o !== 1'b0) begin bad++;
         $display("FAIL bp_hold got=%h/%b exp=a/0", wb_data_o, in_ready_o); end
      out_ready_i = 1'b1;
      step();
      total++; if (wb_data_o !== 32'hB || wb_addr_o !== 5'd2 || in_ready_o !== 1'b1) begin bad++;
         $display("FAIL bp_second got=%h/%0d/%b exp=b/2/1", wb_data_o, wb_addr_o, in_ready_o); end
      step();
      total++; if (wb_data_o !== 32'hC || out_valid_o !== 1'b1) begin bad++;
         $display("FAIL bp_third got=%h/%b exp=c/1", wb_data_o, out_valid_o); end
      in_valid_i = 1'b0;
      step();
      total++; if (out_valid_o !== 1'b0 || wb_cnt_o !== 32'd4) begin bad++;
         $display("FAIL bp_cnt got=%b/%0d exp=0/4", out_valid_o, wb_cnt_o); end
   endtask

   task automatic test_mux();
      out_ready_i = 1'b1;
      drive(1'b1, 1'b0, 5'd7, 4'b0110, 32'h0, 32'h11, 32'h22, 32'h0);
      step();
      total++; if (wb_data_o !== 32'h11) begin bad++; $display("FAIL mux_prio got=%h exp=11", wb_data_o); end
      drive(1'b1, 1'b0, 5'd7, 4'b0000, 32'h55, 32'h11, 32'h22, 32'h33);
      step();
      total++; if (wb_data_o !== 32'h0) begin bad++; $display("FAIL mux_none got=%h exp=0", wb_data_o); end
      drive(1'b1, 1'b0, 5'd7, 4'b1000, 32'h55, 32'h11, 32'h22, 32'h33);
      step();
      total++; if (wb_data_o !== 32'h33) begin bad++; $display("FAIL mux_top got=%h exp=33", wb_data_o); end
      in_valid_i = 1'b0;
      step();
   endtask

   task automatic test_zero_suppress();
      out_ready_i = 1'b1;
      drive(1'b1, 1'b1, 5'd0, 4'b0001, 32'h99, 32'h0, 32'h0, 32'h0);
      step();
      total++; if (out_valid_o !== 1'b1 || wb_flag_o !== 1'b0) begin bad++;
         $display("FAIL zero_flag got=%b/%b exp=1/0", out_valid_o, wb_flag_o); end
      in_valid_i = 1'b0;
      step();
      total++; if (wb_cnt_o !== 32'd4) begin bad++; $display("FAIL zero_cnt got=%0d exp=4", wb_cnt_o); end
   endtask

   task automatic test_flush();
      out_ready_i = 1'b0;
      drive(1'b1, 1'b1, 5'd9, 4'b0001, 32'h91, 32'h0, 32'h0, 32'h0);
      step();
      drive(1'b1, 1'b1, 5'd10, 4'b0001, 32'h92, 32'h0, 32'h0, 32'h0);
      step();
      out_ready_i = 1'b1; flush_i = 1'b1;
      drive(1'b1, 1'b1, 5'd11, 4'b0001, 32'h93, 32'h0, 32'h0, 32'h0);
      step();
      flush_i = 1'b0; in_valid_i = 1'b0;
      total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || wb_flag_o !== 1'b0) begin bad++;
         $display("FAIL flush_state got=%b/%b/%b exp=0/1/0", out_valid_o, in_ready_o, wb_flag_o); end
      total++; if (wb_cnt_o !== 32'd4) begin bad++; $display("FAIL flush_cnt got=%0d exp=4", wb_cnt_o); end
      step();
      total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_discard got=%b exp=0", out_valid_o); end
   endtask

   task automatic test_stream();
      rst = 1'b1; #2; rst = 1'b0;
      out_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 5'(i + 1), 4'b0100, 32'h0, 32'h0, 32'h100 + i, 32'h0);
         step();
         total++; if (out_valid_o !== 1'b1 || wb_data_o !== 32'h100 + i) begin bad++;
            $display("FAIL stream_%0d got=%b/%h exp=1/%h", i, out_valid_o, wb_data_o, 32'h100 + i); end
      end
      in_valid_i = 1'b0;
      step();
      total++; if (wb_cnt_o !== 32'd10) begin bad++; $display("FAIL stream_cnt got=%0d exp=10", wb_cnt_o); end
      drive(1'b1, 1'b1, 5'd4, 4'b0001, 32'h77, 32'h0, 32'h0, 32'h0);
      step();
      step();
      rst = 1'b1;
      #1;
      total++; if ({out_valid_o, wb_flag_o, wb_addr_o, wb_data_o, wb_cnt_o} !== 71'd0 || in_ready_o !== 1'b1) begin bad++;
         $display("FAIL async_rst got=%b/%b/%h/%h/%h/%b exp=0s,ready=1", out_valid_o, wb_flag_o,
                  wb_addr_o, wb_data_o, wb_cnt_o, in_ready_o); end
      in_valid_i = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_mux();
      test_zero_suppress();
      test_flush();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Parametrised writeback pipeline stage between the LSU stage and the register file. It selects the writeback value from NUM_SRC result sources (ALU, LSU, CSR, MUL/DIV, ...) using a one-hot select. It adds a valid/ready handshake with a 2-entry skid buffer so upstream never sees a combinational ready path from the regfile side. It supports flush, optional x0-write suppression, and a retired-writeback counter.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, width of destination register address
NUM_SRC, 4, number of result sources; index 0 has highest priority
ZERO_SUPPRESS, 1, when 1 a write to address 0 has wb_flag_o forced to 0
CNT_W, 32, width of the retired-writeback counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
flush_i  in  1  discard all buffered entries
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat
in_flag_i  in  1  beat requests a register write
in_addr_i  in  ADDR_W  destination register
in_sel_i  in  NUM_SRC  one-hot source select
in_data_i  in  NUM_SRC*DATA_W  packed source results; source k at bits [k*DATA_W +: DATA_W]
out_valid_o  out  1  output beat valid
out_ready_i  in  1  regfile side accepts the beat
wb_flag_o  out  1  write enable for the head beat
wb_addr_o  out  ADDR_W  head beat address
wb_data_o  out  DATA_W  head beat data
wb_cnt_o  out  CNT_W  number of retired beats with wb_flag_o=1

Behaviour:
- Reset (asynchronous, rst=1): both entries invalid; count=0; out_valid_o=0; wb_flag_o=0; wb_addr_o=0; wb_data_o=0; wb_cnt_o=0; in_ready_o=1.
- Source select, combinational before storage:
  - Lowest set bit of in_sel_i wins if more than one bit is set.
  - in_sel_i=0 gives data 0.
  - If ZERO_SUPPRESS=1 and in_addr_i=0, the stored flag is 0.
- Storage: 2-entry FIFO of {flag, addr, data}. Entry 0 (head) drives the wb_* outputs directly from flops. Entry 1 is the skid slot.
- in_ready_o = (count<2), registered-equivalent. It depends only on stored state, never on out_ready_i.
- Push = in_valid_i & in_ready_o. Pop = out_valid_o & out_ready_i. out_valid_o = (count>0).
- Latency: a beat pushed into an empty stage appears on the outputs on the next cycle. Sustained throughput is 1 beat/cycle when out_ready_i stays 1.
- Push and pop in the same cycle:
  - count=1: head is replaced by the new beat; count stays 1.
  - count=2: no push is possible; the skid entry moves to the head; count becomes 1.
- Push only: the beat goes to the first free entry.
- Pop only: the skid entry moves to the head; the vacated entry's flag is cleared.
- When out_valid_o=0, wb_flag_o=0, so an invalid head never writes the regfile. wb_addr_o and wb_data_o hold their last values.
- Flush: at the next edge count=0 and all flags are cleared. The same-cycle push is discarded and the same-cycle pop does not count. in_ready_o=1 the following cycle.
- wb_cnt_o increments by 1 on each pop with wb_flag_o=1. It wraps modulo 2^CNT_W and is unaffected by flush.
- Reset asserted mid-transfer: state clears immediately and asynchronously; in-flight beats are lost.

Decomposition:
- Shared package/define file: FIFO depth constant (2) and an entry struct/field layout {flag, addr, data}.
- One sub-module: wb_src_mux, a combinational parametrised one-hot priority mux (NUM_SRC x DATA_W to DATA_W). The FIFO and counter stay in the top.

Test Plan:
- Reset, then push flag=1, addr=5, sel=4'b0010, src1=0xDEADBEEF with out_ready_i=1 -> next cycle out_valid_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF, wb_flag_o=1; wb_cnt_o=1 after the pop.
- Hold out_ready_i=0 and push 3 beats A,B,C -> A and B accepted; in_ready_o=0 when C is offered. Release ready -> A then B emerge in order; C is accepted once in_ready_o=1.
- Push with sel=4'b0110, src1=0x11, src2=0x22 -> wb_data_o=0x11. Push with sel=0 -> wb_data_o=0.
- Push addr=0, flag=1 with ZERO_SUPPRESS=1 -> out_valid_o=1, wb_flag_o=0, and wb_cnt_o unchanged on pop.
- Fill 2 entries, then assert flush_i together with in_valid_i -> next cycle out_valid_o=0 and in_ready_o=1; the new beat is not stored.
- Streaming 10 beats with out_ready_i=1 -> one output per cycle after 1 cycle of latency; wb_cnt_o=10. Assert rst mid-stream -> outputs are 0 immediately, without waiting for a clock edge.
